// File: rtl/obi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : obi_mem_arbiter
// Purpose  : Round-robin arbiter that shares one OBI memory port between the
//            instruction and data masters. Responses are routed back in order
//            through an ID FIFO.
// Revision : 1.0  initial release
// ============================================================================
module obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 instr_req_i,
    output logic                                 instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                instr_addr_i,
    output logic                                 instr_rvalid_o,
    output logic [31:0]                          instr_rdata_o,
    input  logic                                 data_req_i,
    output logic                                 data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                data_addr_i,
    input  logic                                 data_we_i,
    input  logic [3:0]                           data_be_i,
    input  logic [31:0]                          data_wdata_i,
    output logic                                 data_rvalid_o,
    output logic [31:0]                          data_rdata_o,
    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    output logic [3:0]                           mem_be_o,
    output logic [31:0]                          mem_wdata_o,
    input  logic                                 mem_rvalid_i,
    input  logic [31:0]                          mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int   CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int   PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic c_sel_instr = 1'b0;
    localparam logic c_sel_data  = 1'b1;

    logic             r_fifo [0:MAX_OUTSTANDING-1];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_last_grant;
    logic             r_lock;
    logic             r_lock_sel;
    logic             r_err;

    logic             w_sel;
    logic             w_sel_req;
    logic             w_not_full;
    logic             w_nonempty;
    logic             w_mem_req;
    logic             w_accept;
    logic             w_pop;
    logic             w_head;

    always_comb begin
        w_sel = c_sel_instr;
        if (r_lock) begin
            w_sel = r_lock_sel;
        end else if (instr_req_i && data_req_i) begin
            w_sel = ~r_last_grant;
        end else if (data_req_i) begin
            w_sel = c_sel_data;
        end
    end

    assign w_sel_req  = (w_sel == c_sel_data) ? data_req_i : instr_req_i;
    assign w_not_full = (r_count < CNT_W'(MAX_OUTSTANDING));
    assign w_nonempty = (r_count != '0);
    assign w_mem_req  = w_sel_req && w_not_full;
    assign w_accept   = w_mem_req && mem_gnt_i;
    assign w_pop      = mem_rvalid_i && w_nonempty;
    assign w_head     = r_fifo[r_rd_ptr];

    assign mem_req_o   = w_mem_req && !rst_i;
    assign instr_gnt_o = mem_req_o && mem_gnt_i && (w_sel == c_sel_instr);
    assign data_gnt_o  = mem_req_o && mem_gnt_i && (w_sel == c_sel_data);

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = 32'h0;
        if (w_sel == c_sel_data) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_rvalid_o = !rst_i && w_pop && (w_head == c_sel_instr);
    assign data_rvalid_o  = !rst_i && w_pop && (w_head == c_sel_data);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign outstanding_o  = r_count;
    assign err_o          = r_err;

    // Pointers wrap explicitly so that non-power-of-2 depths work.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= c_sel_instr;
            end
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_last_grant <= c_sel_instr;
            r_lock       <= 1'b0;
            r_lock_sel   <= c_sel_instr;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= (r_wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
                r_last_grant     <= w_sel;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - 1'b1;
            end

            // A locked master that withdraws its request breaks the OBI handshake.
            if (w_accept) begin
                r_lock <= 1'b0;
            end else if (r_lock && !w_sel_req) begin
                r_lock <= 1'b0;
                r_err  <= 1'b1;
            end else if (w_mem_req && !mem_gnt_i) begin
                r_lock     <= 1'b1;
                r_lock_sel <= w_sel;
            end

            if (mem_rvalid_i && !w_nonempty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_mem_arbiter
// Purpose  : Directed self-checking bench for obi_mem_arbiter (depth 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_obi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_gnt, data_we, data_rvalid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [1:0]  outstanding;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    obi_mem_arbiter #(.MAX_OUTSTANDING(2), .ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_addr_i(data_addr),
        .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .outstanding_o(outstanding), .err_o(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 0;
    endtask

    initial begin
        rst = 1; idle();
        instr_addr = 0; data_addr = 0; data_we = 0; data_be = 0; data_wdata = 0; mem_rdata = 0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err, 0);
        tick(); rst = 0;

        // Single instruction read, response two cycles after the request
        instr_req = 1; instr_addr = 32'h0020_0000; mem_gnt = 1;
        @(negedge clk);
        check("t1_instr_gnt", instr_gnt, 1);
        check("t1_data_gnt", data_gnt, 0);
        check("t1_addr", mem_addr, 32'h0020_0000);
        check("t1_be", mem_be, 4'hF);
        check("t1_we", mem_we, 0);
        check("t1_outst0", outstanding, 0);
        tick(); idle();
        @(negedge clk);
        check("t1_outst1", outstanding, 1);
        check("t1_no_rvalid_early", instr_rvalid, 0);
        tick(); mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t1_instr_rvalid", instr_rvalid, 1);
        check("t1_instr_rdata", instr_rdata, 32'hDEAD_BEEF);
        check("t1_data_rvalid", data_rvalid, 0);
        tick(); idle();
        @(negedge clk);
        check("t1_outst_back0", outstanding, 0);

        // Both masters continuously: DATA first, then alternating; rvalid one cycle later
        tick();
        data_addr = 32'h0000_4000; data_we = 0; data_be = 4'hF; instr_addr = 32'h0000_0100;
        for (int i = 0; i < 7; i++) begin
            instr_req = (i < 6); data_req = (i < 6); mem_gnt = 1;
            mem_rvalid = (i > 0); mem_rdata = 32'h100 + i;
            @(negedge clk);
            if (i < 6) begin
                check("t2_data_gnt", data_gnt, (i % 2 == 0));
                check("t2_instr_gnt", instr_gnt, (i % 2 == 1));
                check("t2_addr", mem_addr, (i % 2 == 0) ? 32'h0000_4000 : 32'h0000_0100);
            end
            if (i > 0) begin
                check("t2_data_rvalid", data_rvalid, ((i - 1) % 2 == 0));
                check("t2_instr_rvalid", instr_rvalid, ((i - 1) % 2 == 1));
            end
            tick();
        end
        idle();
        @(negedge clk);
        check("t2_outst", outstanding, 0);

        // Stalled data write with a competing instruction request
        tick();
        data_req = 1; data_we = 1; data_be = 4'b0011; data_wdata = 32'h1234_5678;
        data_addr = 32'h0000_1000; instr_req = 1; instr_addr = 32'h0030_0000;
        for (int c = 1; c <= 4; c++) begin
            mem_gnt = (c == 4);
            @(negedge clk);
            check("t3_addr", mem_addr, 32'h0000_1000);
            check("t3_wdata", mem_wdata, 32'h1234_5678);
            check("t3_be", mem_be, 4'b0011);
            check("t3_we", mem_we, 1);
            check("t3_data_gnt", data_gnt, (c == 4));
            check("t3_instr_gnt", instr_gnt, 0);
            tick();
        end
        data_req = 0; mem_gnt = 1;
        @(negedge clk);
        check("t3_instr_next", instr_gnt, 1);
        check("t3_instr_addr", mem_addr, 32'h0030_0000);
        tick(); idle(); mem_rvalid = 1; mem_rdata = 32'hAAAA_0001;
        @(negedge clk);
        check("t3_rsp1_data", data_rvalid, 1);
        check("t3_rsp1_instr", instr_rvalid, 0);
        tick(); mem_rdata = 32'hAAAA_0002;
        @(negedge clk);
        check("t3_rsp2_instr", instr_rvalid, 1);
        check("t3_rsp2_data", data_rvalid, 0);
        check("t3_rsp2_rdata", instr_rdata, 32'hAAAA_0002);
        tick(); idle();
        @(negedge clk);
        check("t3_outst", outstanding, 0);
        check("t3_err", err, 0);

        // Back-pressure at full FIFO; a pop does not unblock a push in the same cycle
        tick();
        instr_req = 1; mem_gnt = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t4_gnt", instr_gnt, 1);
            tick();
        end
        @(negedge clk);
        check("t4_full_req", mem_req, 0);
        check("t4_full_gnt", instr_gnt, 0);
        check("t4_full_outst", outstanding, 2);
        tick(); mem_rvalid = 1;
        @(negedge clk);
        check("t4_pop_rvalid", instr_rvalid, 1);
        check("t4_no_bypass", instr_gnt, 0);
        tick(); mem_rvalid = 0;
        @(negedge clk);
        check("t4_third_gnt", instr_gnt, 1);
        check("t4_outst1", outstanding, 1);
        tick(); instr_req = 0;
        @(negedge clk);
        check("t4_outst2", outstanding, 2);

        // Reset with two outstanding, then late responses
        tick();
        instr_req = 1; mem_gnt = 1; rst = 1;
        #1;
        check("t6_outst_rst", outstanding, 0);
        check("t6_req_in_rst", mem_req, 0);
        check("t6_gnt_in_rst", instr_gnt, 0);
        tick(); rst = 0; idle();
        for (int c = 0; c < 2; c++) begin
            mem_rvalid = 1; mem_rdata = 32'hBAD0_0000 + c;
            @(negedge clk);
            check("t6_late_instr", instr_rvalid, 0);
            check("t6_late_data", data_rvalid, 0);
            tick();
        end
        mem_rvalid = 0;
        @(negedge clk);
        check("t6_err", err, 1);

        // Empty-FIFO response: error is sticky and cleared only by reset
        tick(); rst = 1; #1;
        check("t5_err_cleared", err, 0);
        tick(); rst = 0;
        mem_rvalid = 1;
        @(negedge clk);
        check("t5_no_instr_rvalid", instr_rvalid, 0);
        check("t5_no_data_rvalid", data_rvalid, 0);
        tick(); mem_rvalid = 0;
        repeat (3) begin
            @(negedge clk);
            check("t5_err_sticky", err, 1);
            tick();
        end
        rst = 1; #1;
        check("t5_err_rst", err, 0);
        tick(); rst = 0;

        // Locked master withdrawing its request flags an error
        data_req = 1; data_we = 0; mem_gnt = 0;
        @(negedge clk);
        check("t7_err_before", err, 0);
        tick(); data_req = 0;
        tick();
        @(negedge clk);
        check("t7_err_drop", err, 1);
        check("t7_outst", outstanding, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one single-ported OBI memory slave between the core's instruction-fetch and data OBI master ports. The core, the coprocessor and all bus signals run on one clock.
- Sits between the core top and a unified SRAM or bus bridge.
- Fair round-robin arbitration; address phase held locked while the memory stalls.
- Outstanding-transaction ID FIFO routes each in-order response back to its owner.

Parameters:
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO (1..8); maximum accepted-but-unanswered transactions.
- ADDR_WIDTH, 32, address width on all ports.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  instruction master request.
- instr_gnt_o  out  1  instruction address-phase grant.
- instr_addr_i  in  ADDR_WIDTH  instruction address.
- instr_rvalid_o  out  1  instruction response valid.
- instr_rdata_o  out  32  instruction read data.
- data_req_i  in  1  data master request.
- data_gnt_o  out  1  data grant.
- data_addr_i  in  ADDR_WIDTH  data address.
- data_we_i  in  1  data write enable.
- data_be_i  in  4  data byte enables.
- data_wdata_i  in  32  data write data.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  32  data read data.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  memory byte enables.
- mem_wdata_o  out  32  memory write data.
- mem_rvalid_i  in  1  memory response valid; responses arrive in order.
- mem_rdata_i  in  32  memory read data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy.
- err_o  out  1  sticky protocol error.

Behaviour:
- State registers:
  - ID FIFO: 1 bit per entry, 0=INSTR, 1=DATA; plus count.
  - last_grant register.
  - lock and lock_sel registers.
  - err register.
- Reset (rst_i high, asynchronous):
  - FIFO empty, count=0, last_grant=INSTR, lock=0, err_o=0.
  - mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o and data_rvalid_o are forced 0 while rst_i is high.
- Selection (combinational):
  - If lock=1, sel=lock_sel.
  - Otherwise, with one requester active, sel is that requester.
  - With both active, sel is the requester other than last_grant.
  - With none active, mem_req_o=0.
- Request gating: mem_req_o = (selected req) AND (count < MAX_OUTSTANDING). There is no same-cycle full bypass: a pop in the same cycle does not unblock a push.
- Address mux:
  - sel=INSTR: mem_addr_o=instr_addr_i, mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
  - sel=DATA: the data_* signals pass straight through.
- Grant:
  - x_gnt_o = mem_req_o AND mem_gnt_i AND (sel==x).
  - Grant is zero-latency combinational; at most one grant per cycle.
- Accept (mem_req_o AND mem_gnt_i):
  - Push sel into the FIFO.
  - last_grant <= sel.
  - lock <= 0.
- Stall (mem_req_o AND NOT mem_gnt_i): lock <= 1, lock_sel <= sel. The selection is held until that request is granted, which keeps the OBI address phase stable.
- If a locked requester drops its request (a master protocol violation), then err_o <= 1 and lock <= 0.
- Response:
  - instr_rvalid_o = mem_rvalid_i AND non-empty AND head==INSTR.
  - data_rvalid_o = mem_rvalid_i AND non-empty AND head==DATA.
  - Both rdata outputs carry mem_rdata_i directly.
  - On mem_rvalid_i with a non-empty FIFO, pop the head.
  - mem_rvalid_i with an empty FIFO: response dropped (no rvalid_o), err_o <= 1.
- Simultaneous push and pop: count is unchanged, and the head advances correctly. This also applies when count==MAX_OUTSTANDING−1 or when count==1, in which case the pushed entry becomes the new head.
- Pointer wrap: read and write pointers wrap modulo MAX_OUTSTANDING; the design must support non-power-of-2 depths.
- Reset mid-transaction: all outstanding IDs are discarded. Late memory responses after reset set err_o and are never forwarded.
- outstanding_o = count (registered). err_o is sticky until reset.

Test Plan:
- Single instr read at addr 0x0020_0000, mem_gnt_i=1, rvalid 2 cycles later with rdata 0xDEADBEEF.
  - Required: instr_gnt_o=1 in the request cycle, mem_be_o=4'hF, mem_we_o=0.
  - Required: instr_rvalid_o=1 with 0xDEADBEEF; data_rvalid_o stays 0; outstanding_o goes 0→1→0.
- Both masters request continuously, mem_gnt_i=1 every cycle, rvalid one cycle later.
  - Required: grants alternate DATA, INSTR, DATA, … (first DATA, since last_grant resets to INSTR).
  - Required: each rvalid is routed to its own master in order.
- Data write 0x1234_5678 with be=4'b0011 while mem_gnt_i is held low for 3 cycles and instr_req_i is also raised.
  - Required: mem_addr_o, mem_wdata_o and mem_be_o stay on the data request for all 4 cycles.
  - Required: data_gnt_o pulses only in cycle 4; the instr request is granted next.
- MAX_OUTSTANDING=2, three back-to-back instr requests, no rvalid.
  - Required: 2 grants, then mem_req_o=0 and outstanding_o=2.
  - Required: after one rvalid, the third request is granted in the following cycle, not the same cycle.
- mem_rvalid_i pulsed with an empty FIFO.
  - Required: no rvalid_o on either master, err_o=1 and held.
  - Required: rst_i pulse clears err_o to 0.
- rst_i asserted with 2 outstanding, then 2 late mem_rvalid_i pulses.
  - Required: outstanding_o=0 immediately, no rvalid_o forwarded, err_o=1.
